// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/D memory port arbiter.
package mem_port_arbiter_pkg;

  // FSM state encodings
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Requester IDs; also the select value of the address/write-data muxes
  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_D  = 1'b1;

  // Default watchdog limit and counter width
  localparam int DEF_TIMEOUT = 16;
  localparam int DEF_CNT_W   = 5;

  // Round-robin pick: a lone requester wins outright, a tie goes to the
  // requester that was not served last.
  function automatic logic pick_grant(input logic if_req,
                                      input logic d_req,
                                      input logic last);
    logic g;
    if (if_req && d_req) begin
      g = ~last;
    end else if (d_req) begin
      g = GNT_D;
    end else begin
      g = GNT_IF;
    end
    return g;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_mux32.sv
// 32-bit 2:1 select mux: sel=0 passes a, sel=1 passes b.
module mem_port_arbiter_mux32 (
  input  logic        sel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  // Pure combinational select
  always_comb begin
    y = sel ? b : a;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between an
// instruction-fetch requester (read-only) and a data requester (read/write),
// with a watchdog that aborts accesses the memory never acknowledges.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             state_q, state_d;
  logic               grant_q, grant_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic               if_done_q, if_done_d;
  logic               d_done_q, d_done_d;
  logic               err_q, err_d;
  logic [31:0]        if_rdata_q, if_rdata_d;
  logic [31:0]        d_rdata_q, d_rdata_d;

  // Next-state, grant, watchdog and output computation
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    mem_req_d  = 1'b0;
    mem_we_d   = 1'b0;
    if_done_d  = 1'b0;
    d_done_d   = 1'b0;
    err_d      = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (if_req || d_req) begin
          grant_d   = pick_grant(if_req, d_req, last_q);
          state_d   = S_BUSY;
          mem_req_d = 1'b1;
          // Write enable is captured at grant time so it stays clean for the
          // whole access even if the requester lets go of its request.
          mem_we_d  = (grant_d == GNT_D) && d_we;
          cnt_d     = '0;
        end
      end

      S_BUSY: begin
        if (mem_ack) begin
          // An ack always beats a simultaneous timeout. Writes leave d_rdata
          // untouched, since the memory returns nothing meaningful for them.
          if (grant_q == GNT_IF) begin
            if_rdata_d = mem_rdata;
            if_done_d  = 1'b1;
          end else begin
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end
            d_done_d = 1'b1;
          end
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          // Watchdog expired: finish the access as failed, rdata kept.
          if_done_d = (grant_q == GNT_IF);
          d_done_d  = (grant_q == GNT_D);
          err_d     = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d     = cnt_q + CNT_ONE;
          mem_req_d = 1'b1;
          mem_we_d  = mem_we_q;
        end
      end

      S_DONE: begin
        // No arbitration here: the finished requester gets a cycle to drop req.
        last_d  = grant_q;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      grant_q    <= GNT_IF;
      last_q     <= GNT_D;
      cnt_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
      err_q      <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      if_done_q  <= if_done_d;
      d_done_q   <= d_done_d;
      err_q      <= err_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_we   = mem_we_q;
  assign if_done  = if_done_q;
  assign d_done   = d_done_q;
  assign err      = err_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

  // Address mux: select comes only from the grant register, so there is no
  // combinational path from a request input to mem_addr.
  mem_port_arbiter_mux32 u_addr_mux32 (
    .sel (grant_q),
    .a   (if_addr),
    .b   (d_addr),
    .y   (mem_addr)
  );

  // Write-data mux: IF never writes, so its side is tied to zero.
  mem_port_arbiter_mux32 u_wdata_mux32 (
    .sel (grant_q),
    .a   (32'h0000_0000),
    .b   (d_wdata),
    .y   (mem_wdata)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by a
// randomized stream, checked against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  // Reference model state: who was served last, what each requester has
  // pending, and the read data each requester should currently hold.
  bit          last_m;
  bit          pend_if;
  bit          pend_d;
  logic [31:0] if_rd_m;
  logic [31:0] d_rd_m;

  mem_port_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_done   (if_done),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_done    (d_done),
    .d_rdata   (d_rdata),
    .err       (err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_quiet(input string tag);
    check_eq({tag, "_mem_req"}, mem_req, 0);
    check_eq({tag, "_mem_we"},  mem_we,  0);
    check_eq({tag, "_if_done"}, if_done, 0);
    check_eq({tag, "_d_done"},  d_done,  0);
    check_eq({tag, "_err"},     err,     0);
  endtask

  // Serve one access. Called at the falling edge of an idle cycle with the
  // requests already driven; returns at the falling edge of the following
  // idle cycle. ack_dly = busy cycle (0-based) in which the memory acks;
  // anything beyond TIMEOUT-1 means the memory never acks.
  task automatic serve(input int ack_dly, input bit drop, input logic [31:0] rd);
    bit          g;
    bit          abort;
    bit          we_m;
    int          k_end;
    logic [31:0] addr_m;
    logic [31:0] wdata_m;
    g       = (pend_if && pend_d) ? !last_m : pend_d;
    abort   = (ack_dly > TIMEOUT - 1);
    k_end   = abort ? TIMEOUT - 1 : ack_dly;
    we_m    = g && d_we;
    addr_m  = g ? d_addr : if_addr;
    wdata_m = g ? d_wdata : 32'h0;
    for (int k = 0; k <= k_end; k++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      check_eq("busy_mem_req", mem_req, 1);
      if (k == 0 || k == k_end) begin
        check_eq("busy_mem_addr",  mem_addr,  addr_m);
        check_eq("busy_mem_we",    mem_we,    we_m);
        check_eq("busy_mem_wdata", mem_wdata, wdata_m);
        check_eq("busy_if_done",   if_done,   0);
        check_eq("busy_d_done",    d_done,    0);
      end
      if (drop && k == 0) begin
        if (g) d_req = 1'b0;
        else   if_req = 1'b0;
      end
      if (!abort && k == ack_dly) begin
        mem_ack   = 1'b1;
        mem_rdata = rd;
      end
    end
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (!abort) begin
      if (!g)        if_rd_m = rd;
      else if (!we_m) d_rd_m = rd;
    end
    check_eq("done_if_done",  if_done,  !g);
    check_eq("done_d_done",   d_done,   g);
    check_eq("done_err",      err,      abort);
    check_eq("done_mem_req",  mem_req,  0);
    check_eq("done_if_rdata", if_rdata, if_rd_m);
    check_eq("done_d_rdata",  d_rdata,  d_rd_m);
    $display("txn %0d: served=%s addr=%h we=%0d ack_dly=%0d drop=%0d abort=%0d rdata_if=%h rdata_d=%h",
             n_txn, g ? "D" : "IF", addr_m, we_m, ack_dly, drop, abort, if_rd_m, d_rd_m);
    n_txn++;
    last_m = g;
    if (g) begin pend_d = 1'b0; d_req = 1'b0; end
    else   begin pend_if = 1'b0; if_req = 1'b0; end
    @(negedge clk);
    check_eq("idle_mem_req", mem_req, 0);
    check_eq("idle_if_done", if_done, 0);
    check_eq("idle_d_done",  d_done,  0);
    check_eq("idle_err",     err,     0);
  endtask

  task automatic model_reset();
    last_m  = 1'b1;
    pend_if = 1'b0;
    pend_d  = 1'b0;
    if_rd_m = '0;
    d_rd_m  = '0;
  endtask

  initial begin
    int ack_dly;
    rst_n     = 1'b0;
    if_req    = 1'b0;
    if_addr   = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check_all_quiet("reset");
    check_eq("reset_if_rdata", if_rdata, 0);
    check_eq("reset_d_rdata",  d_rdata,  0);
    rst_n = 1'b1;
    @(negedge clk);

    // IF-only fetch, ack in the second busy cycle
    if_addr = 32'h0040_0000; if_req = 1'b1; pend_if = 1'b1;
    serve(1, 1'b0, 32'h2008_000A);

    // D write: d_rdata must stay unchanged
    d_addr = 32'h1001_0004; d_wdata = 32'hDEAD_BEEF; d_we = 1'b1;
    d_req = 1'b1; pend_d = 1'b1;
    serve(0, 1'b0, 32'h1234_5678);

    // D read that is never acknowledged: watchdog abort
    d_we = 1'b0; d_addr = 32'h1001_0008; d_req = 1'b1; pend_d = 1'b1;
    serve(TIMEOUT, 1'b0, 32'hBAD0_BAD0);

    // Ack on the very last watchdog cycle wins over the timeout
    d_addr = 32'h1001_000C; d_req = 1'b1; pend_d = 1'b1;
    serve(TIMEOUT - 1, 1'b0, 32'h0BAD_F00D);

    // D drops its request mid-access; done still pulses
    d_addr = 32'h1001_0010; d_req = 1'b1; pend_d = 1'b1;
    serve(3, 1'b1, 32'hCAFE_0001);

    // Reset in the middle of a busy access, then a stale ack
    if_addr = 32'h0040_0100; if_req = 1'b1;
    @(negedge clk);
    check_eq("pre_rst_mem_req", mem_req, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_quiet("midrst");
    check_eq("midrst_if_rdata", if_rdata, 0);
    check_eq("midrst_d_rdata",  d_rdata,  0);
    model_reset();
    if_req = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    mem_ack = 1'b0;
    check_all_quiet("stale_ack");
    check_eq("stale_if_rdata", if_rdata, 0);
    @(negedge clk);
    check_all_quiet("stale_ack2");

    // Simultaneous requests right after reset: IF, then D, then IF again
    if_addr = 32'h0040_0200; d_addr = 32'h1001_0020; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1; pend_if = 1'b1; pend_d = 1'b1;
    serve(0, 1'b0, 32'hA000_0001);
    serve(2, 1'b0, 32'hB000_0002);
    if_req = 1'b1; d_req = 1'b1; pend_if = 1'b1; pend_d = 1'b1;
    serve(1, 1'b0, 32'hA000_0003);
    serve(0, 1'b0, 32'hB000_0004);

    // Randomized stream
    for (int i = 0; i < 60; i++) begin
      if (!pend_if && !pend_d) begin
        if ($urandom_range(0, 3) == 0) begin
          // idle cycle with a stray ack that must be ignored
          mem_ack = 1'b1; mem_rdata = $urandom;
          @(negedge clk);
          mem_ack = 1'b0;
          check_eq("rnd_idle_mem_req", mem_req, 0);
          check_eq("rnd_idle_if_rdata", if_rdata, if_rd_m);
          check_eq("rnd_idle_d_rdata", d_rdata, d_rd_m);
        end
        pend_if = ($urandom_range(0, 2) != 1);
        pend_d  = ($urandom_range(0, 2) != 0) || !pend_if;
        if_addr = $urandom;
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_we    = $urandom_range(0, 1);
        if_req  = pend_if;
        d_req   = pend_d;
      end
      ack_dly = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 5);
      serve(ack_dly, ($urandom_range(0, 4) == 0), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
